keypad_time_encoder: RTL
========================

// Module: keypad_time_encoder
// PURPOSE
//  Keypad-to-BCD time entry for the microwave front panel. Debounces the 0-9 and CLEAR keys and encodes each accepted digit.
//  Accepted digits shift into a 3-digit M:ST:SO BCD time register, microwave style (new digit enters units, older digits move left).
//  The min/sec_t/sec_on outputs feed the timer load path and the 7-segment decoder.
// PARAMETERS
//  DEBOUNCE_CYCLES  4  clocks a single key code must stay stable before it is accepted (>=2)
//  CNT_W            3  debounce counter width; must hold DEBOUNCE_CYCLES-1
// PORTS
//  clk        in   1  single system clock
//  rst_n      in   1  asynchronous, active-low reset
//  en         in   1  1 = entry allowed (oven idle); 0 = ignore keys
//  key        in  10  raw digit keys, key[d] high = digit d pressed, asynchronous
//  key_clr    in   1  raw CLEAR key, asynchronous
//  min        out  4  BCD minutes 0-9
//  sec_t      out  4  BCD seconds tens 0-5
//  sec_on     out  4  BCD seconds units 0-9
//  digit_stb  out  1  1-clk pulse when a digit or clear is committed
//  key_err    out  1  1-clk pulse when a debounced digit is rejected
//  time_zero  out  1  combinational: min==sec_t==sec_on==0
// BEHAVIOUR
//  Reset: min=sec_t=sec_on=0, digit_stb=key_err=0, digit count=0, FSM=IDLE, synchronisers=0.
//  Inputs {key_clr,key} pass through a 2-flop synchroniser. The code is valid when exactly one of the 11 bits is high.
//  FSM:
//   IDLE: en && code valid -> DEBOUNCE, latch code, counter=0.
//   DEBOUNCE: sync code != latched code or !en -> IDLE, no commit. Otherwise counter++.
//    When counter == DEBOUNCE_CYCLES-1 -> COMMIT.
//   COMMIT (1 clk): apply the action below -> WAIT_REL.
//   WAIT_REL: stay while any synced key bit is high; all released -> IDLE. One commit per press, no auto-repeat.
//  Commit actions (registered on COMMIT, visible next clk):
//   CLEAR: all digits=0, count=0, digit_stb=1.
//   Digit d, count<3 and sec_on<=5: min<=sec_t, sec_t<=sec_on, sec_on<=d, count++, digit_stb=1.
//   Digit d, count==3 or sec_on>5: no change, key_err=1. sec_t must never exceed 5.
//  Latency: a clean press held from clk edge 0 updates the outputs at edge DEBOUNCE_CYCLES+3.
//  Multiple keys high, or a bounce shorter than DEBOUNCE_CYCLES: nothing committed, no key_err.
//  en is sampled each clk. Dropping en in DEBOUNCE aborts the press. Dropping en in COMMIT still completes the commit.
//  Digits hold their values while en=0. Leading-zero digits are stored as 0; blanking is done downstream.
//  rst_n low at any time (including mid-DEBOUNCE) clears everything immediately.
// STRUCTURE
//  Package keypad_pkg holds:
//   state encoding IDLE/DEBOUNCE/COMMIT/WAIT_REL
//   BCD_W=4, NUM_KEYS=11, CLR_IDX=10, SEC_T_MAX=5, MAX_DIGITS=3
//  Sub-module key_debouncer: synchroniser, one-hot check, debounce counter and FSM. Outputs a 1-clk accept pulse plus the key code.
//  The top level holds the BCD shift register, digit count and error logic.
// TESTING (DEBOUNCE_CYCLES=4)
//  1. Press 1, 3, 0, each held 10 clk with 5 clk release -> 0:0:1, 0:1:3, 1:3:0.
//     3 digit_stb pulses, each 7 clk after its press; time_zero 1 -> 0.
//  2. Enter 7, then press 2 -> key_err pulse; digits stay 0:0:7.
//  3. Enter 1,2,3, then press 4 -> key_err; digits stay 1:2:3. Then CLEAR -> 0:0:0, digit_stb, time_zero=1.
//  4. Key 5 toggling with 2-clk glitches, then key[2]|key[5] together for 20 clk -> no digit_stb, no key_err, no change.
//  5. Hold key 8 for 50 clk -> exactly one commit. en=0 during a press of 9 -> ignored.
//  6. Assert rst_n=0 mid-DEBOUNCE, after entering 4 -> all outputs 0 asynchronously.
//     After release the next press commits normally.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the microwave keypad time-entry block:
// FSM encoding, key-code layout and the one-hot / encode helpers.
package keypad_pkg;

  localparam int BCD_W      = 4;
  localparam int NUM_KEYS   = 11;
  localparam int CLR_IDX    = 10;
  localparam int SEC_T_MAX  = 5;
  localparam int MAX_DIGITS = 3;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    COMMIT   = 2'd2,
    WAIT_REL = 2'd3
  } kstate_e;

  typedef struct packed {
    logic is_clr;
    bcd_t digit;
  } key_code_t;

  // A code is only usable when exactly one of the digit/CLEAR lines is high.
  function automatic logic is_one_hot(input logic [NUM_KEYS-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      n += int'(v[i]);
    end
    return (n == 1);
  endfunction

  function automatic key_code_t encode_key(input logic [NUM_KEYS-1:0] v);
    key_code_t k;
    k = '0;
    for (int i = 0; i < CLR_IDX; i++) begin
      if (v[i]) begin
        k.digit = bcd_t'(i);
      end
    end
    k.is_clr = v[CLR_IDX];
    return k;
  endfunction

endpackage

// File: rtl/keypad_time_encoder_if.sv
// Front-panel keypad bundle: raw keys and enable toward the encoder,
// BCD time digits and status pulses back out.
interface keypad_time_encoder_if;
  import keypad_pkg::*;

  logic                en;
  logic [CLR_IDX-1:0]  key;
  logic                key_clr;
  bcd_t                min;
  bcd_t                sec_t;
  bcd_t                sec_on;
  logic                digit_stb;
  logic                key_err;
  logic                time_zero;

  modport master (
    output en, key, key_clr,
    input  min, sec_t, sec_on, digit_stb, key_err, time_zero
  );

  modport slave (
    input  en, key, key_clr,
    output min, sec_t, sec_on, digit_stb, key_err, time_zero
  );

endinterface

// File: rtl/keypad_time_encoder_key_debouncer.sv
// Synchronises the raw key lines, qualifies a single pressed key, debounces
// it and emits a one-clock accept pulse with the encoded key code.
module key_debouncer
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [NUM_KEYS-1:0] raw_keys,
  output logic                accept,
  output key_code_t           code
);

  logic [NUM_KEYS-1:0] sync_q1;
  logic [NUM_KEYS-1:0] sync_q2;
  logic [NUM_KEYS-1:0] latched_q;
  logic [CNT_W-1:0]    cnt_q;
  kstate_e             state_q;
  kstate_e             state_d;
  logic                code_valid;
  logic                code_same;
  logic                any_key;
  logic                cnt_done;

  assign code_valid = is_one_hot(sync_q2);
  assign code_same  = (sync_q2 == latched_q);
  assign any_key    = |sync_q2;
  assign cnt_done   = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

  // NOTE: non-blocking assignments keep sync_q2 one clock behind sync_q1;
  // blocking ones would collapse the two stages into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= raw_keys;
      sync_q2 <= sync_q1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (en && code_valid) begin
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!code_same || !en) begin
          state_d = IDLE;
        end else if (cnt_done) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        state_d = WAIT_REL;
      end
      WAIT_REL: begin
        if (!any_key) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Key code capture and stability counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latched_q <= '0;
      cnt_q     <= '0;
    end else if (state_q == IDLE && en && code_valid) begin
      latched_q <= sync_q2;
      cnt_q     <= '0;
    end else if (state_q == DEBOUNCE && code_same && en && !cnt_done) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // en is deliberately not used here: a commit already reached completes.
  always_comb begin
    accept = (state_q == COMMIT);
    code   = encode_key(latched_q);
  end

endmodule

// File: rtl/keypad_time_encoder.sv
// Microwave-style M:ST:SO time entry: accepted digits shift in from the
// units position, CLEAR zeroes the time, illegal entries raise key_err.
module keypad_time_encoder
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  keypad_time_encoder_if.slave bus
);

  localparam int DCNT_W = $clog2(MAX_DIGITS + 1);

  logic              accept;
  key_code_t         code;
  bcd_t              min_q, min_d;
  bcd_t              sec_t_q, sec_t_d;
  bcd_t              sec_on_q, sec_on_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic              stb_q, stb_d;
  logic              err_q, err_d;
  logic              digit_ok;

  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debouncer (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (bus.en),
    .raw_keys ({bus.key_clr, bus.key}),
    .accept   (accept),
    .code     (code)
  );

  // Shifting a units digit above 5 into the tens place would give an
  // invalid seconds value, so such an entry is refused.
  assign digit_ok = (dcnt_q < DCNT_W'(MAX_DIGITS)) &&
                    (sec_on_q <= bcd_t'(SEC_T_MAX));

  always_comb begin
    min_d    = min_q;
    sec_t_d  = sec_t_q;
    sec_on_d = sec_on_q;
    dcnt_d   = dcnt_q;
    stb_d    = 1'b0;
    err_d    = 1'b0;
    if (accept) begin
      if (code.is_clr) begin
        min_d    = '0;
        sec_t_d  = '0;
        sec_on_d = '0;
        dcnt_d   = '0;
        stb_d    = 1'b1;
      end else if (digit_ok) begin
        min_d    = sec_t_q;
        sec_t_d  = sec_on_q;
        sec_on_d = code.digit;
        dcnt_d   = dcnt_q + 1'b1;
        stb_d    = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q    <= '0;
      sec_t_q  <= '0;
      sec_on_q <= '0;
      dcnt_q   <= '0;
      stb_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      min_q    <= min_d;
      sec_t_q  <= sec_t_d;
      sec_on_q <= sec_on_d;
      dcnt_q   <= dcnt_d;
      stb_q    <= stb_d;
      err_q    <= err_d;
    end
  end

  assign bus.min       = min_q;
  assign bus.sec_t     = sec_t_q;
  assign bus.sec_on    = sec_on_q;
  assign bus.digit_stb = stb_q;
  assign bus.key_err   = err_q;
  assign bus.time_zero = (min_q == '0) && (sec_t_q == '0) && (sec_on_q == '0);

endmodule
